// File: rtl/fc_loader_pkg.sv
// rtl/fc_loader_pkg.sv - shared state encoding and width helper for the FC weight loader
package fc_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fc_weight_staging.sv
// rtl/fc_weight_staging.sv - indexed-write staging register array, flattened onto one output bus
module fc_weight_staging #(
  parameter int N  = 50,
  parameter int W  = 8,
  parameter int IW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [IW-1:0] i_idx,
  input  logic [W-1:0]  i_data,
  output logic [N*W-1:0] o_weights
);

  logic [N*W-1:0] r_weights;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weights <= '0;
    end else if (i_we) begin
      for (int i = 0; i < N; i++) begin
        if (i_idx == IW'(i)) r_weights[i*W +: W] <= i_data;
      end
    end
  end

  assign o_weights = r_weights;

endmodule

// File: rtl/fc_weight_loader.sv
// rtl/fc_weight_loader.sv - streams weight words into staging and pulses the FC memory write enable once
// Optional trailing checksum word enabled by FC_LOADER_CHECKSUM_EN.
module fc_weight_loader
  import fc_loader_pkg::*;
#(
  parameter int FLATTENED_LENGTH          = 50,
  parameter int FULLYCONNECTED_DATA_WIDTH = 8,
  localparam int CW = count_width(FLATTENED_LENGTH),
  localparam int W  = FULLYCONNECTED_DATA_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  input  logic [W-1:0]                  in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [FLATTENED_LENGTH*W-1:0] fc_weights,
  output logic                          fc_wr_en_n,
  output logic [CW-1:0]                 word_count,
  output logic                          busy,
  output logic                          done,
  output logic                          error
);

  localparam logic [CW-1:0] LAST = CW'(FLATTENED_LENGTH - 1);

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic           r_wr_en_n;
  logic           r_done;
  logic           w_we;

  // Abort wins over a word presented in the same cycle, so nothing is staged then.
  assign w_we = (r_state == S_LOAD) && in_valid && !abort;

`ifdef FC_LOADER_CHECKSUM_EN
  logic [W-1:0] r_sum;
  logic         r_error;
  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_wr_en_n <= 1'b1;
      r_done    <= 1'b0;
`ifdef FC_LOADER_CHECKSUM_EN
      r_sum     <= '0;
      r_error   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef FC_LOADER_CHECKSUM_EN
      r_error <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (start && !abort) begin
            r_state <= S_LOAD;
            r_count <= '0;
`ifdef FC_LOADER_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (in_valid) begin
            r_count <= r_count + CW'(1);
`ifdef FC_LOADER_CHECKSUM_EN
            r_sum   <= r_sum + in_data;
            if (r_count == LAST) r_state <= S_CHECK;
`else
            if (r_count == LAST) begin
              r_state   <= S_COMMIT;
              r_wr_en_n <= 1'b0;
            end
`endif
          end
        end
`ifdef FC_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_count <= '0;
          end else if (in_valid) begin
            if (in_data == r_sum) begin
              r_state   <= S_COMMIT;
              r_wr_en_n <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_COMMIT: begin
          r_state   <= S_IDLE;
          r_wr_en_n <= 1'b1;
          r_done    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  fc_weight_staging #(
    .N  (FLATTENED_LENGTH),
    .W  (W),
    .IW (CW)
  ) u_staging (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_idx     (r_count),
    .i_data    (in_data),
    .o_weights (fc_weights)
  );

  assign in_ready   = (r_state == S_LOAD) || (r_state == S_CHECK);
  assign busy       = (r_state != S_IDLE);
  assign fc_wr_en_n = r_wr_en_n;
  assign done       = r_done;
  assign word_count = r_count;

endmodule

// File: tb/tb_fc_weight_loader.sv
// tb/tb_fc_weight_loader.sv - randomized self-checking bench for fc_weight_loader (N=4, W=8)
module tb_fc_weight_loader;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] fc_weights;
  logic           fc_wr_en_n;
  logic [2:0]     word_count;
  logic           busy;
  logic           done;
  logic           error;

  fc_weight_loader #(
    .FLATTENED_LENGTH          (N),
    .FULLYCONNECTED_DATA_WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .fc_weights (fc_weights),
    .fc_wr_en_n (fc_wr_en_n),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wr_pulses = 0;
  int exp_pulses = 0;
  int ready_bad = 0;
  int n_staged = 0;
  logic [W-1:0] stg [N];
  logic [W-1:0] ws  [N];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory-side view: each low sample of the enable is one write.
  always @(negedge clk) if (!rst && !fc_wr_en_n) wr_pulses++;

  function automatic logic [N*W-1:0] staged_bus();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = stg[i];
    return v;
  endfunction

  function automatic logic [W-1:0] word_sum();
    logic [W-1:0] s = '0;
    for (int i = 0; i < N; i++) s = s + ws[i];
    return s;
  endfunction

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_staged = 0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap, input bit store);
    bit hs = 1'b0;
    int n = 0;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (!in_ready) ready_bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    do begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!hs && n < 20);
    if (!hs) check_eq("handshake_timeout", 0, 1);
    in_valid = 1'b0;
    if (store) begin
      stg[n_staged] = w;
      n_staged++;
    end
  endtask

  task automatic send_words(input int n, input int gap);
    for (int i = 0; i < n; i++) send_word(ws[i], (gap < 0) ? $urandom_range(0, 2) : gap, 1'b1);
  endtask

  // Called just after the final handshake edge: write cycle, then done cycle.
  task automatic finish_and_expect_commit(input string tag);
`ifdef FC_LOADER_CHECKSUM_EN
    send_word(word_sum(), 0, 1'b0);
`endif
    exp_pulses++;
    @(negedge clk);
    check_eq({tag, "_wr_en_n"}, fc_wr_en_n, 1'b0);
    check_eq({tag, "_weights"}, fc_weights, staged_bus());
    check_eq({tag, "_done_early"}, done, 1'b0);
    @(negedge clk);
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_wr_en_n_off"}, fc_wr_en_n, 1'b1);
    check_eq({tag, "_word_count"}, word_count, N);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1'b0);
    check_eq({tag, "_wr_en_n"}, fc_wr_en_n, 1'b1);
    check_eq({tag, "_weights"}, fc_weights, '0);
    check_eq({tag, "_word_count"}, word_count, 0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_error"}, error, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) stg[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic back-to-back load.
    ws[0] = 8'h11; ws[1] = 8'h22; ws[2] = 8'h33; ws[3] = 8'h44;
    start_pulse();
    send_words(N, 0);
    finish_and_expect_commit("basic");
    @(negedge clk);
    check_eq("basic_done_pulse", done, 1'b0);

    // Gapped valid: ready must hold high across idle cycles in LOAD.
    for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
    ready_bad = 0;
    start_pulse();
    send_words(N, 3);
    finish_and_expect_commit("gapped");
    check_eq("gapped_ready_held", ready_bad, 0);

    // Randomized loads with random gaps.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      start_pulse();
      send_words(N, -1);
      finish_and_expect_commit("random");
    end

    // Abort after two words: partial staging stays visible, no write.
    for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
    start_pulse();
    send_words(2, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_word_count", word_count, 0);
    check_eq("abort_weights", fc_weights, staged_bus());
    check_eq("abort_no_write", wr_pulses, exp_pulses);
    for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
    @(posedge clk); #1;
    start_pulse();
    send_words(N, 0);
    finish_and_expect_commit("post_abort");

    // start together with abort in IDLE does nothing.
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check_eq("start_abort_busy", busy, 1'b0);
    check_eq("start_abort_ready", in_ready, 1'b0);

    // start during the done cycle opens a new load.
    for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
    @(posedge clk); #1;
    start_pulse();
    send_words(N, 0);
    finish_and_expect_commit("pre_chain");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_staged = 0;
    @(negedge clk);
    check_eq("chain_busy", busy, 1'b1);
    check_eq("chain_word_count", word_count, 0);
    for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
    send_words(N, 1);
    finish_and_expect_commit("chain");

    // Asynchronous reset part-way through a load.
    for (int i = 0; i < N; i++) ws[i] = W'($urandom_range(0, 255));
    @(posedge clk); #1;
    start_pulse();
    send_words(3, 0);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < N; i++) stg[i] = '0;
    check_reset_values("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midreset_no_write", wr_pulses, exp_pulses);

`ifdef FC_LOADER_CHECKSUM_EN
    ws[0] = 8'h80; ws[1] = 8'h80; ws[2] = 8'h01; ws[3] = 8'h02;
    @(posedge clk); #1;
    start_pulse();
    send_words(N, 0);
    finish_and_expect_commit("csum_ok");
    @(posedge clk); #1;
    start_pulse();
    send_words(N, 0);
    send_word(8'h04, 0, 1'b0);
    @(negedge clk);
    check_eq("csum_bad_error", error, 1'b1);
    check_eq("csum_bad_busy", busy, 1'b0);
    check_eq("csum_bad_wr_en_n", fc_wr_en_n, 1'b1);
    @(negedge clk);
    check_eq("csum_bad_error_pulse", error, 1'b0);
    check_eq("csum_bad_done", done, 1'b0);
`endif

    repeat (2) @(negedge clk);
    check_eq("total_write_pulses", wr_pulses, exp_pulses);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
